// File: rtl/display_scheduler_if.sv
// Source/display bundle of the round-robin display scheduler: source requests
// and words in, grant pulse and the word shown on the scan driver out.
interface display_scheduler_if #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
);
    logic [N_SRC-1:0]    req;
    logic [16*N_SRC-1:0] data_in;
    logic [N_SRC-1:0]    ack;
    logic [15:0]         dis_data;
    logic [SRC_W-1:0]    active_src;
    logic                busy;

    modport master (
        output req, data_in,
        input  ack, dis_data, active_src, busy
    );

    modport slave (
        input  req, data_in,
        output ack, dis_data, active_src, busy
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin arbiter that shares one 16-bit display word between N_SRC sources,
// latching the winner's word and holding it for DWELL_CYCLES clocks per grant.
module display_scheduler #(
    parameter int N_SRC        = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int SRC_W        = $clog2(N_SRC)
) (
    input  logic                clk1,
    input  logic                rst,
    display_scheduler_if.slave  bus
);
    localparam int               CNT_W    = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SRC_W-1:0] r_ptr;
    logic [SRC_W-1:0] r_active_src;
    logic [N_SRC-1:0] r_ack;
    logic [15:0]      r_dis_data;
    logic             r_busy;

    logic             w_found;
    logic [SRC_W-1:0] w_win;
    logic             w_arb;

    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int step);
        return SRC_W'((int'(base) + step) % N_SRC);
    endfunction

    // Scan from farthest to nearest so the source closest after r_ptr wins;
    // r_ptr itself is reached at step N_SRC, i.e. searched last.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = N_SRC; k >= 1; k--) begin
            if (bus.req[wrap_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(r_ptr, k);
            end
        end
    end

    assign w_arb = (r_state == IDLE) || (r_cnt == CNT_LAST);

    always_ff @(posedge clk1) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ptr        <= SRC_W'(N_SRC - 1);
            r_active_src <= '0;
            r_ack        <= '0;
            r_dis_data   <= 16'h0000;
            r_busy       <= 1'b0;
        end else if (w_arb) begin
            r_cnt <= '0;
            if (w_found) begin
                r_dis_data   <= bus.data_in[16*w_win +: 16];
                r_ack        <= ONE_HOT0 << w_win;
                r_active_src <= w_win;
                r_ptr        <= w_win;
                r_state      <= HOLD;
                r_busy       <= 1'b1;
            end else begin
                // Nobody waiting: keep the last word on the display rather than blanking.
                r_ack   <= '0;
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
            r_ack <= '0;
        end
    end

    assign bus.ack        = r_ack;
    assign bus.dis_data   = r_dis_data;
    assign bus.active_src = r_active_src;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler (N_SRC=4, DWELL_CYCLES=4): vector table,
// hand-written dwell sequences, and a grant scoreboard checked on every ack pulse.
module tb_display_scheduler;
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  exp_ack;
        logic        exp_busy;
        logic [1:0]  exp_src;
        logic [15:0] exp_dis;
    } vec_t;

    typedef struct {
        logic [1:0]  src;
        logic [15:0] data;
    } sb_t;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic        rst_q = 1'b1;
    logic [15:0] words [4];
    int          n_total = 0;
    int          n_pass  = 0;
    sb_t         exp_q [$];
    sb_t         sb_e;
    vec_t        vecs [6];

    display_scheduler_if #(.N_SRC(4)) bus ();

    display_scheduler #(.N_SRC(4), .DWELL_CYCLES(4)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 clk1 = ~clk1;

    assign bus.data_in = {words[3], words[2], words[1], words[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Advance one rising edge and return 2 time units later, where outputs are sampled
    // and the next inputs are driven.
    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] ack, input logic busy,
                              input logic [1:0] src, input logic [15:0] dis);
        check({tag, "_ack"},  32'(bus.ack),        32'(ack));
        check({tag, "_busy"}, 32'(bus.busy),       32'(busy));
        check({tag, "_src"},  32'(bus.active_src), 32'(src));
        check({tag, "_dis"},  32'(bus.dis_data),   32'(dis));
    endtask

    always @(posedge clk1) rst_q <= rst;

    // Scoreboard: every ack pulse must match the oldest expected grant.
    always @(negedge clk1) begin
        if (rst_q) begin
            check("ack_during_reset", 32'(bus.ack), 32'd0);
        end else if (bus.ack !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ack", 32'(bus.ack), 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_ack", 32'(bus.ack),        32'(4'b0001 << sb_e.src));
                check("sb_src", 32'(bus.active_src), 32'(sb_e.src));
                check("sb_dis", 32'(bus.dis_data),   32'(sb_e.data));
            end
        end
    end

    initial begin
        words[0] = 16'h8A00;
        words[1] = 16'h1280;
        words[2] = 16'h1900;
        words[3] = 16'h0F7F;

        // Single request from IDLE after src 0 was last granted: src 2 wins, holds 4 cycles.
        vecs[0] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 16'h1900};
        vecs[1] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 16'h1900};
        vecs[2] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 16'h1900};
        vecs[3] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 16'h1900};
        vecs[4] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 16'h1900};
        vecs[5] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 16'h1900};

        // Reset held 3 cycles with every source requesting.
        bus.req = 4'b1111;
        rst     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs("reset", 4'b0000, 1'b0, 2'd0, 16'h0000);
        end

        // Full contention: grants 0,1,2,3,0 at edges 1,5,9,13,17 after release.
        for (int i = 0; i < 5; i++) exp_q.push_back('{2'(i % 4), words[i % 4]});
        rst = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            logic [1:0] s;
            tick();
            s = 2'(((e - 1) / 4) % 4);
            check_outs("contention", ((e - 1) % 4 == 0) ? (4'b0001 << s) : 4'b0000, 1'b1, s, words[s]);
        end
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        check_outs("contention_idle", 4'b0000, 1'b0, 2'd0, words[0]);

        // Table-driven single request.
        for (int i = 0; i < 6; i++) begin
            rst     = vecs[i].rst;
            bus.req = vecs[i].req;
            if (vecs[i].exp_ack != 4'b0000) exp_q.push_back('{vecs[i].exp_src, vecs[i].exp_dis});
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_busy,
                       vecs[i].exp_src, vecs[i].exp_dis);
        end

        // Sole persistent requester: re-granted every 4 cycles; a data change mid-dwell
        // only shows up at the next grant.
        bus.req = 4'b0010;
        exp_q.push_back('{2'd1, 16'h1280});
        for (int e = 1; e <= 12; e++) begin
            tick();
            check_outs("sole", (e % 4 == 1) ? 4'b0010 : 4'b0000, 1'b1, 2'd1,
                       (e < 5) ? 16'h1280 : 16'h2200);
            if (e == 2) begin
                words[1] = 16'h2200;
                exp_q.push_back('{2'd1, 16'h2200});
                exp_q.push_back('{2'd1, 16'h2200});
            end
        end
        bus.req = 4'b0000;
        tick();
        check_outs("sole_idle", 4'b0000, 1'b0, 2'd1, 16'h2200);

        // Skip and late arrival: src 3 granted, src 0 pulses mid-dwell, src 1 arrives and wins.
        bus.req = 4'b1000;
        exp_q.push_back('{2'd3, 16'h0F7F});
        tick();
        check_outs("skip_g3", 4'b1000, 1'b1, 2'd3, 16'h0F7F);
        bus.req = 4'b0001;
        tick();
        check_outs("skip_e2", 4'b0000, 1'b1, 2'd3, 16'h0F7F);
        bus.req = 4'b0010;
        exp_q.push_back('{2'd1, 16'h2200});
        tick();
        tick();
        check_outs("skip_e4", 4'b0000, 1'b1, 2'd3, 16'h0F7F);
        tick();
        check_outs("skip_g1", 4'b0010, 1'b1, 2'd1, 16'h2200);
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        check_outs("skip_idle", 4'b0000, 1'b0, 2'd1, 16'h2200);

        // Reset mid-HOLD at cnt=2, then order restarts at source 0.
        bus.req = 4'b1111;
        exp_q.push_back('{2'd2, 16'h1900});
        tick();
        check_outs("midrst_g2", 4'b0100, 1'b1, 2'd2, 16'h1900);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_outs("midrst_rst", 4'b0000, 1'b0, 2'd0, 16'h0000);
        tick();
        rst = 1'b0;
        exp_q.push_back('{2'd0, 16'h8A00});
        tick();
        check_outs("midrst_g0", 4'b0001, 1'b1, 2'd0, 16'h8A00);
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        check_outs("final_idle", 4'b0000, 1'b0, 2'd0, 16'h8A00);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
